// File: rtl/l2_flush_ctrl.sv
// L2 flush sequencer: walks every (set, way) through the status-register block and evicts each valid line.
// Per line: 3 cycles (lookup, response, advance) plus eviction cycles; eviction held until evict_ready, gated by free MSHRs and evict_stall.
module l2_flush_ctrl #(
    parameter int SET_BITS   = 8,
    parameter int WAY_BITS   = 3,
    parameter int MSHR_CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req_valid,
    output logic                  flush_req_ready,
    output logic                  flush_done,
    input  logic                  ongoing_flush,
    input  logic [SET_BITS:0]     flush_set,
    input  logic [WAY_BITS:0]     flush_way,
    input  logic [MSHR_CNT_W-1:0] mshr_cnt,
    input  logic                  evict_stall,
    output logic                  set_ongoing_flush,
    output logic                  clr_ongoing_flush,
    output logic                  clr_flush_set,
    output logic                  incr_flush_set,
    output logic                  clr_flush_way,
    output logic                  incr_flush_way,
    output logic                  rd_req_valid,
    output logic [SET_BITS-1:0]   rd_set,
    output logic [WAY_BITS-1:0]   rd_way,
    input  logic                  rd_rsp_valid,
    input  logic                  rd_rsp_line_valid,
    input  logic                  rd_rsp_dirty,
    output logic                  evict_valid,
    input  logic                  evict_ready,
    output logic [SET_BITS-1:0]   evict_set,
    output logic [WAY_BITS-1:0]   evict_way,
    output logic                  evict_dirty
);

    localparam logic [SET_BITS-1:0] LAST_SET = '1;
    localparam logic [WAY_BITS-1:0] LAST_WAY = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT_RSP,
        EVICT,
        ADVANCE,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_issued;
    logic [SET_BITS-1:0] r_evict_set;
    logic [WAY_BITS-1:0] r_evict_way;
    logic                r_evict_dirty;

    assign evict_set   = r_evict_set;
    assign evict_way   = r_evict_way;
    assign evict_dirty = r_evict_dirty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_issued      <= 1'b0;
            r_evict_set   <= '0;
            r_evict_way   <= '0;
            r_evict_dirty <= 1'b0;
        end else begin
            r_state <= w_next;
            // Lookup address is still current in WAIT_RSP: the index registers only move in ADVANCE.
            if (r_state == WAIT_RSP && rd_rsp_valid && rd_rsp_line_valid) begin
                r_evict_set   <= flush_set[SET_BITS-1:0];
                r_evict_way   <= flush_way[WAY_BITS-1:0];
                r_evict_dirty <= rd_rsp_dirty;
            end
            if (evict_valid && evict_ready) begin
                r_issued <= 1'b0;
            end else if (evict_valid) begin
                r_issued <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        flush_req_ready   = 1'b0;
        flush_done        = 1'b0;
        set_ongoing_flush = 1'b0;
        clr_ongoing_flush = 1'b0;
        clr_flush_set     = 1'b0;
        incr_flush_set    = 1'b0;
        clr_flush_way     = 1'b0;
        incr_flush_way    = 1'b0;
        rd_req_valid      = 1'b0;
        rd_set            = '0;
        rd_way            = '0;
        evict_valid       = 1'b0;
        case (r_state)
            IDLE: begin
                // Qualified by rst so nothing is accepted or pulsed while reset is held.
                flush_req_ready = rst && !ongoing_flush;
                if (flush_req_valid && flush_req_ready) begin
                    set_ongoing_flush = 1'b1;
                    clr_flush_set     = 1'b1;
                    clr_flush_way     = 1'b1;
                    w_next            = LOOKUP;
                end
            end
            LOOKUP: begin
                rd_req_valid = 1'b1;
                rd_set       = flush_set[SET_BITS-1:0];
                rd_way       = flush_way[WAY_BITS-1:0];
                w_next       = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rd_rsp_valid) begin
                    w_next = rd_rsp_line_valid ? EVICT : ADVANCE;
                end
            end
            EVICT: begin
                // Once raised, valid is held by r_issued regardless of later MSHR/stall changes.
                evict_valid = r_issued || (mshr_cnt != '0 && !evict_stall);
                if (evict_valid && evict_ready) begin
                    w_next = ADVANCE;
                end
            end
            ADVANCE: begin
                if (flush_way[WAY_BITS-1:0] != LAST_WAY) begin
                    incr_flush_way = 1'b1;
                    w_next         = LOOKUP;
                end else begin
                    clr_flush_way  = 1'b1;
                    incr_flush_set = 1'b1;
                    w_next         = (flush_set[SET_BITS-1:0] == LAST_SET) ? DONE : LOOKUP;
                end
            end
            DONE: begin
                clr_ongoing_flush = 1'b1;
                flush_done        = 1'b1;
                w_next            = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Directed bench for l2_flush_ctrl on a 4-set x 2-way cache with a status-register model and lookup responder.
module tb_l2_flush_ctrl;

    localparam int SB = 2;
    localparam int WB = 1;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_req_valid = 1'b0;
    logic          flush_req_ready;
    logic          flush_done;
    logic          ongoing_flush;
    logic [SB:0]   flush_set;
    logic [WB:0]   flush_way;
    logic [MW-1:0] mshr_cnt = 3'd4;
    logic          evict_stall = 1'b0;
    logic          set_ongoing_flush, clr_ongoing_flush, clr_flush_set, incr_flush_set;
    logic          clr_flush_way, incr_flush_way;
    logic          rd_req_valid;
    logic [SB-1:0] rd_set;
    logic [WB-1:0] rd_way;
    logic          rd_rsp_valid, rd_rsp_line_valid, rd_rsp_dirty;
    logic          evict_valid;
    logic          evict_ready = 1'b1;
    logic [SB-1:0] evict_set;
    logic [WB-1:0] evict_way;
    logic          evict_dirty;

    logic          tbl_v [0:3][0:1];
    logic          tbl_d [0:3][0:1];
    logic          hold_en = 1'b0;
    logic [SB-1:0] hold_set = '0;
    logic [WB-1:0] hold_way = '0;

    logic [2:0] rdq[$];
    logic [3:0] evq[$];
    int n_iw = 0, n_is = 0, n_cw = 0, n_so = 0, n_done = 0;
    int n_acc = 0, n_busy_rdy = 0, n_ev_valid = 0;
    int checks = 0, passed = 0;

    l2_flush_ctrl #(.SET_BITS(SB), .WAY_BITS(WB), .MSHR_CNT_W(MW)) dut (
        .clk(clk), .rst(rst),
        .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready), .flush_done(flush_done),
        .ongoing_flush(ongoing_flush), .flush_set(flush_set), .flush_way(flush_way),
        .mshr_cnt(mshr_cnt), .evict_stall(evict_stall),
        .set_ongoing_flush(set_ongoing_flush), .clr_ongoing_flush(clr_ongoing_flush),
        .clr_flush_set(clr_flush_set), .incr_flush_set(incr_flush_set),
        .clr_flush_way(clr_flush_way), .incr_flush_way(incr_flush_way),
        .rd_req_valid(rd_req_valid), .rd_set(rd_set), .rd_way(rd_way),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_line_valid(rd_rsp_line_valid), .rd_rsp_dirty(rd_rsp_dirty),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_set(evict_set), .evict_way(evict_way), .evict_dirty(evict_dirty)
    );

    always #5 clk = ~clk;

    // Status-register block: pulses take effect on the following edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ongoing_flush <= 1'b0;
            flush_set     <= '0;
            flush_way     <= '0;
        end else begin
            if (set_ongoing_flush) ongoing_flush <= 1'b1;
            if (clr_ongoing_flush) ongoing_flush <= 1'b0;
            if (clr_flush_set) flush_set <= '0;
            else if (incr_flush_set) flush_set <= flush_set + 1'b1;
            if (clr_flush_way) flush_way <= '0;
            else if (incr_flush_way) flush_way <= flush_way + 1'b1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_rsp_valid      <= 1'b0;
            rd_rsp_line_valid <= 1'b0;
            rd_rsp_dirty      <= 1'b0;
        end else begin
            rd_rsp_valid <= 1'b0;
            if (rd_req_valid && !(hold_en && rd_set == hold_set && rd_way == hold_way)) begin
                rd_rsp_valid      <= 1'b1;
                rd_rsp_line_valid <= tbl_v[rd_set][rd_way];
                rd_rsp_dirty      <= tbl_d[rd_set][rd_way];
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rd_req_valid) rdq.push_back({rd_set, rd_way});
            if (evict_valid && evict_ready) evq.push_back({evict_set, evict_way, evict_dirty});
            if (incr_flush_way) n_iw++;
            if (incr_flush_set) n_is++;
            if (clr_flush_way) n_cw++;
            if (set_ongoing_flush) n_so++;
            if (flush_done) n_done++;
            if (flush_req_valid && flush_req_ready) n_acc++;
            if (ongoing_flush && flush_req_ready) n_busy_rdy++;
            if (evict_valid) n_ev_valid++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_tbl();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                tbl_v[s][w] = 1'b0;
                tbl_d[s][w] = 1'b0;
            end
        end
    endtask

    task automatic request(output bit ok);
        ok = 1'b0;
        flush_req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (flush_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        flush_req_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (flush_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input logic [SB-1:0] s, input logic [WB-1:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_req_valid && rd_set == s && rd_way == w) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({flush_req_ready, flush_done, set_ongoing_flush, rd_req_valid, evict_valid,
             evict_set, evict_way, evict_dirty} !== 9'd0)
            $display("FAIL reset_outputs: got %b want 0", {flush_req_ready, flush_done, set_ongoing_flush,
                     rd_req_valid, evict_valid, evict_set, evict_way, evict_dirty});
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (flush_req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", flush_req_ready);
        else passed++;
        checks++;
        if (rd_req_valid !== 1'b0) $display("FAIL idle_rd_req: got %b want 0", rd_req_valid);
        else passed++;
        tick(1);
    endtask

    task automatic test_empty_walk();
        int b_rd, b_ev, b_iw, b_is, b_cw, b_dn;
        bit ok;
        clear_tbl();
        b_rd = rdq.size(); b_ev = evq.size(); b_iw = n_iw; b_is = n_is; b_cw = n_cw; b_dn = n_done;
        request(ok);
        checks++;
        if (!ok) $display("FAIL empty_accept: timed out waiting for ready"); else passed++;
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL empty_done: timed out waiting for flush_done"); else passed++;
        checks++;
        if (rdq.size() - b_rd !== 8) $display("FAIL empty_rd_count: got %0d want 8", rdq.size() - b_rd);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] exp_sw;
            exp_sw = 3'(i);
            if (b_rd + i < rdq.size()) begin
                checks++;
                if (rdq[b_rd + i] !== exp_sw)
                    $display("FAIL empty_rd_order[%0d]: got set %0d way %0d want set %0d way %0d",
                             i, rdq[b_rd + i][2:1], rdq[b_rd + i][0], exp_sw[2:1], exp_sw[0]);
                else passed++;
            end
        end
        checks++;
        if (n_iw - b_iw !== 4) $display("FAIL empty_incr_way: got %0d want 4", n_iw - b_iw); else passed++;
        checks++;
        if (n_is - b_is !== 4) $display("FAIL empty_incr_set: got %0d want 4", n_is - b_is); else passed++;
        checks++;
        if (n_cw - b_cw !== 5) $display("FAIL empty_clr_way: got %0d want 5", n_cw - b_cw); else passed++;
        checks++;
        if (evq.size() - b_ev !== 0) $display("FAIL empty_evicts: got %0d want 0", evq.size() - b_ev); else passed++;
        checks++;
        if (n_done - b_dn !== 1) $display("FAIL empty_done_count: got %0d want 1", n_done - b_dn); else passed++;
        checks++;
        if (flush_set !== 3'd4) $display("FAIL empty_final_set: got %0d want 4", flush_set); else passed++;
        checks++;
        if (ongoing_flush !== 1'b0) $display("FAIL empty_ongoing: got %b want 0", ongoing_flush); else passed++;
    endtask

    task automatic test_evictions();
        int b_ev;
        bit ok;
        clear_tbl();
        tbl_v[1][1] = 1'b1; tbl_d[1][1] = 1'b1;
        tbl_v[2][0] = 1'b1; tbl_d[2][0] = 1'b0;
        b_ev = evq.size();
        request(ok);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL evict_done: timed out waiting for flush_done"); else passed++;
        checks++;
        if (evq.size() - b_ev !== 2) $display("FAIL evict_count: got %0d want 2", evq.size() - b_ev);
        else passed++;
        if (evq.size() - b_ev >= 2) begin
            checks++;
            if (evq[b_ev] !== 4'b0111) $display("FAIL evict_dirty_line: got %b want 0111", evq[b_ev]);
            else passed++;
            checks++;
            if (evq[b_ev + 1] !== 4'b1000) $display("FAIL evict_clean_line: got %b want 1000", evq[b_ev + 1]);
            else passed++;
        end
    endtask

    task automatic test_mshr_gate();
        int b_rd, b_vv;
        bit ok;
        clear_tbl();
        tbl_v[3][0] = 1'b1; tbl_d[3][0] = 1'b1;
        mshr_cnt = 3'd0;
        evict_ready = 1'b0;
        b_rd = rdq.size(); b_vv = n_ev_valid;
        request(ok);
        wait_rd(2'd3, 1'b0, ok);
        checks++;
        if (!ok) $display("FAIL gate_lookup: timed out waiting for lookup of (3,0)"); else passed++;
        tick(6);
        checks++;
        if (n_ev_valid - b_vv !== 0) $display("FAIL gate_no_valid: got %0d valid cycles want 0", n_ev_valid - b_vv);
        else passed++;
        checks++;
        if (rdq.size() - b_rd !== 7) $display("FAIL gate_stalled: got %0d lookups want 7", rdq.size() - b_rd);
        else passed++;
        mshr_cnt = 3'd2;
        @(negedge clk);
        checks++;
        if (evict_valid !== 1'b1) $display("FAIL gate_rise: got %b want 1", evict_valid); else passed++;
    endtask

    task automatic test_evict_hold();
        int b_ev;
        bit ok;
        b_ev = evq.size();
        tick(1);
        evict_stall = 1'b1;
        mshr_cnt = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({evict_valid, evict_set, evict_way, evict_dirty} !== 5'b1_11_0_1)
                $display("FAIL hold_stable[%0d]: got %b want 11101", i,
                         {evict_valid, evict_set, evict_way, evict_dirty});
            else passed++;
        end
        tick(1);
        evict_ready = 1'b1;
        tick(1);
        mshr_cnt = 3'd4;
        evict_stall = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL hold_done: timed out waiting for flush_done"); else passed++;
        checks++;
        if (evq.size() - b_ev !== 1) $display("FAIL hold_handshakes: got %0d want 1", evq.size() - b_ev);
        else passed++;
        if (evq.size() > b_ev) begin
            checks++;
            if (evq[b_ev] !== 4'b1101) $display("FAIL hold_payload: got %b want 1101", evq[b_ev]);
            else passed++;
        end
    endtask

    task automatic test_busy_request();
        int b_so, b_acc, b_busy;
        bit ok, got;
        clear_tbl();
        b_so = n_so; b_acc = n_acc; b_busy = n_busy_rdy;
        flush_req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = flush_req_ready;
        end
        tick(1);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL busy_done1: timed out waiting for flush_done"); else passed++;
        @(negedge clk);
        checks++;
        if (flush_req_ready !== 1'b1) $display("FAIL busy_reaccept: got ready %b want 1", flush_req_ready);
        else passed++;
        tick(1);
        flush_req_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (n_so - b_so !== 2) $display("FAIL busy_set_ongoing: got %0d want 2", n_so - b_so); else passed++;
        checks++;
        if (n_acc - b_acc !== 2) $display("FAIL busy_accepts: got %0d want 2", n_acc - b_acc); else passed++;
        checks++;
        if (n_busy_rdy - b_busy !== 0) $display("FAIL busy_ready: got %0d ready cycles while ongoing want 0",
                                                n_busy_rdy - b_busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int b_rd;
        bit ok;
        clear_tbl();
        hold_en = 1'b1; hold_set = 2'd2; hold_way = 1'b1;
        request(ok);
        wait_rd(2'd2, 1'b1, ok);
        checks++;
        if (!ok) $display("FAIL rstmid_lookup: timed out waiting for lookup of (2,1)"); else passed++;
        tick(2);
        rst = 1'b0;
        flush_req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({flush_req_ready, flush_done, set_ongoing_flush, clr_ongoing_flush, clr_flush_set, incr_flush_set,
             clr_flush_way, incr_flush_way, rd_req_valid, rd_set, rd_way, evict_valid,
             evict_set, evict_way, evict_dirty} !== 17'd0)
            $display("FAIL rstmid_outputs: got %b want 0", {flush_req_ready, flush_done, set_ongoing_flush,
                     clr_ongoing_flush, clr_flush_set, incr_flush_set, clr_flush_way, incr_flush_way,
                     rd_req_valid, rd_set, rd_way, evict_valid, evict_set, evict_way, evict_dirty});
        else passed++;
        tick(1);
        flush_req_valid = 1'b0;
        hold_en = 1'b0;
        rst = 1'b1;
        tick(1);
        b_rd = rdq.size();
        request(ok);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL rstmid_done: timed out waiting for flush_done"); else passed++;
        checks++;
        if (rdq.size() - b_rd !== 8) $display("FAIL rstmid_rd_count: got %0d want 8", rdq.size() - b_rd);
        else passed++;
        if (rdq.size() > b_rd) begin
            checks++;
            if (rdq[b_rd] !== 3'd0) $display("FAIL rstmid_first: got set %0d way %0d want 0,0",
                                             rdq[b_rd][2:1], rdq[b_rd][0]);
            else passed++;
        end
    endtask

    initial begin
        clear_tbl();
        test_reset();
        test_empty_walk();
        test_evictions();
        test_mshr_gate();
        test_evict_hold();
        test_busy_request();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/l2_flush_ctrl.md
Name: l2_flush_ctrl

Overview:
- Control sequencer that drives the flush trigger pulses of the L2 status-register block and reads back its ongoing_flush, flush_set, flush_way and mshr_cnt registers.
- On a flush request it walks every (set, way), looks up each line's state, and issues one eviction request per valid line.
- Eviction requests go to the L2 writeback/MSHR path. The sequencer signals completion once the last way of the last set has been processed.

Parameters:
SET_BITS, 8, log2 of L2 set count (SETS = 2**SET_BITS)
WAY_BITS, 3, log2 of L2 way count (WAYS = 2**WAY_BITS)
MSHR_CNT_W, 3, width of mshr_cnt readback

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush_req_valid  in  1  flush request
flush_req_ready  out  1  request accepted when valid&&ready
flush_done  out  1  one-cycle completion pulse
ongoing_flush  in  1  register readback
flush_set  in  SET_BITS+1  register readback
flush_way  in  WAY_BITS+1  register readback
mshr_cnt  in  MSHR_CNT_W  free MSHR entries
evict_stall  in  1  register readback; blocks new eviction issue
set_ongoing_flush  out  1  trigger pulse
clr_ongoing_flush  out  1  trigger pulse
clr_flush_set  out  1  trigger pulse
incr_flush_set  out  1  trigger pulse
clr_flush_way  out  1  trigger pulse
incr_flush_way  out  1  trigger pulse
rd_req_valid  out  1  tag/state lookup strobe
rd_set  out  SET_BITS  lookup set
rd_way  out  WAY_BITS  lookup way
rd_rsp_valid  in  1  lookup response strobe
rd_rsp_line_valid  in  1  line holds valid data
rd_rsp_dirty  in  1  line is dirty
evict_valid  out  1  eviction request
evict_ready  in  1  eviction accepted
evict_set  out  SET_BITS  eviction payload
evict_way  out  WAY_BITS  eviction payload
evict_dirty  out  1  eviction needs writeback

Behaviour:
- Reset: state IDLE; all outputs 0; payload registers 0; issued flag 0. Reset mid-operation abandons the walk. The status registers reset concurrently, so the next request restarts from set 0, way 0.
- All trigger outputs are single-cycle pulses. The status registers update on the following edge, so the cycle after a pulse sees the new value. No settle state is needed.
- States: IDLE, LOOKUP, WAIT_RSP, EVICT, ADVANCE, DONE.
- IDLE:
  - flush_req_ready = !ongoing_flush.
  - On handshake, pulse set_ongoing_flush, clr_flush_set and clr_flush_way in the same cycle, then go to LOOKUP.
- LOOKUP:
  - rd_req_valid=1 for exactly one cycle.
  - rd_set = flush_set[SET_BITS-1:0]; rd_way = flush_way[WAY_BITS-1:0].
  - Next state WAIT_RSP.
- WAIT_RSP:
  - Wait indefinitely for rd_rsp_valid. rd_rsp_* fields are ignored otherwise.
  - On response with line_valid=1: latch evict_set/evict_way from rd_set/rd_way and evict_dirty from rd_rsp_dirty, then go to EVICT.
  - On response with line_valid=0: go to ADVANCE.
- EVICT:
  - evict_valid = issued || (mshr_cnt != 0 && !evict_stall). issued sets when evict_valid first rises.
  - Once asserted, evict_valid and the payload hold stable until evict_ready, regardless of later mshr_cnt/evict_stall changes.
  - On valid&&ready: clear issued and go to ADVANCE.
- ADVANCE (one cycle):
  - If flush_way[WAY_BITS-1:0] != WAYS-1: pulse incr_flush_way, go to LOOKUP.
  - Else: pulse clr_flush_way and incr_flush_set. If flush_set[SET_BITS-1:0] == SETS-1, go to DONE, otherwise go to LOOKUP.
  - After the final set, flush_set reads SETS, i.e. MSB=1 marks the walk complete.
- DONE (one cycle): pulse clr_ongoing_flush and flush_done, then go to IDLE.
- flush_req_valid outside IDLE is ignored and not queued; flush_req_ready=0 there.
- A flush_req_valid that arrives in the same cycle as the DONE pulse is accepted only in a later IDLE cycle, once ongoing_flush has cleared.
- Per line the minimum cost is 3 cycles (LOOKUP, WAIT_RSP, ADVANCE) plus the EVICT cycles when an eviction is issued.

Test Plan:
- SET_BITS=2, WAY_BITS=1, regs model attached, all lookups return line_valid=0:
  - required: 8 rd_req pulses in order (0,0),(0,1),(1,0)…(3,1);
  - 4 incr_flush_way pulses, 4 incr_flush_set pulses, 5 clr_flush_way pulses;
  - zero evict_valid; one flush_done; final flush_set=4; ongoing_flush back to 0.
- Same configuration, only (set 1, way 1) valid and dirty -> exactly one eviction with evict_set=1, evict_way=1, evict_dirty=1; clean valid line at (2,0) -> eviction with evict_dirty=0.
- EVICT entered with mshr_cnt=0 for 5 cycles -> evict_valid stays 0. mshr_cnt set to 2 -> evict_valid rises the same cycle.
- evict_valid high with evict_ready low for 3 cycles while evict_stall rises and mshr_cnt drops to 0 -> valid and payload remain stable; a single handshake occurs when ready rises.
- flush_req_valid held while ongoing_flush=1 -> flush_req_ready=0 and no set_ongoing_flush pulse. After DONE -> exactly one new acceptance.
- Assert rst during WAIT_RSP of (2,1), then release and re-request -> all outputs 0 during reset; the first rd_req after restart is (0,0).
